// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and operand-forwarding control for the five-stage MIPS core.
// Tracks a shadow of each in-flight instruction's destination register, remaining
// Tnew and result source kind in E, M and W. From that shadow it derives:
// - the per-stage forward-source selects;
// - the D/E/M operand forwarding mux selects;
// - the F/D stall and the D/E flush.
// Source-kind codes come from the core header; code 0 means no result.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_A3,
  input  logic [1:0] D_tnew,
  input  logic [2:0] D_src,
  input  logic       D_is_md,
  input  logic       E_md_busy,
  output logic       stall,
  output logic       F_en,
  output logic       D_en,
  output logic       E_clr,
  output logic [2:0] E_fwd_src_sel,
  output logic [2:0] M_fwd_src_sel,
  output logic [2:0] W_fwd_src_sel,
  output logic [1:0] D_rs_fwd,
  output logic [1:0] D_rt_fwd,
  output logic [1:0] E_rs_fwd,
  output logic [1:0] E_rt_fwd,
  output logic [1:0] M_rt_fwd
);

  // Shadow records of the E, M and W pipeline stages.
  logic [4:0] r_E_a3, r_E_rs, r_E_rt;
  logic [1:0] r_E_tnew;
  logic [2:0] r_E_src;
  logic [4:0] r_M_a3, r_M_rt;
  logic [1:0] r_M_tnew;
  logic [2:0] r_M_src;
  logic [4:0] r_W_a3;
  logic [1:0] r_W_tnew;
  logic [2:0] r_W_src;

  logic       w_hz_rs, w_hz_rt, w_hz_md;

  // Tnew counts down one per stage and sticks at zero.
  function automatic logic [1:0] dec_tnew(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A D operand must wait if a producer in E or M is not ready by the time it is used.
  function automatic logic hazard(
    input logic [4:0] r, input logic [1:0] tuse,
    input logic [4:0] ea3, input logic [1:0] etn,
    input logic [4:0] ma3, input logic [1:0] mtn
  );
    return (r != 5'd0) && (tuse != 2'd3) &&
           (((ea3 == r) && (tuse < etn)) || ((ma3 == r) && (tuse < mtn)));
  endfunction

  // Nearest matching producer wins; a matching but unready producer selects the
  // register file value, which is safe because the stall logic holds D then.
  function automatic logic [1:0] d_sel(
    input logic [4:0] r,
    input logic [4:0] ea3, input logic [1:0] etn,
    input logic [4:0] ma3, input logic [1:0] mtn,
    input logic [4:0] wa3, input logic [1:0] wtn
  );
    logic [1:0] s;
    s = 2'd0;
    if (r != 5'd0) begin
      if (ea3 == r)      s = (etn == 2'd0) ? 2'd1 : 2'd0;
      else if (ma3 == r) s = (mtn == 2'd0) ? 2'd2 : 2'd0;
      else if (wa3 == r) s = (wtn == 2'd0) ? 2'd3 : 2'd0;
    end
    return s;
  endfunction

  function automatic logic [1:0] e_sel(
    input logic [4:0] r,
    input logic [4:0] ma3, input logic [1:0] mtn,
    input logic [4:0] wa3, input logic [1:0] wtn
  );
    logic [1:0] s;
    s = 2'd0;
    if (r != 5'd0) begin
      if (ma3 == r)      s = (mtn == 2'd0) ? 2'd2 : 2'd0;
      else if (wa3 == r) s = (wtn == 2'd0) ? 2'd3 : 2'd0;
    end
    return s;
  endfunction

  function automatic logic [2:0] src_sel(input logic [4:0] a3, input logic [1:0] tn,
                                         input logic [2:0] src);
    return ((a3 != 5'd0) && (tn == 2'd0)) ? src : 3'd0;
  endfunction

  // Advance the shadow pipeline; a stall injects an empty record into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_E_a3   <= '0;
      r_E_rs   <= '0;
      r_E_rt   <= '0;
      r_E_tnew <= '0;
      r_E_src  <= '0;
      r_M_a3   <= '0;
      r_M_rt   <= '0;
      r_M_tnew <= '0;
      r_M_src  <= '0;
      r_W_a3   <= '0;
      r_W_tnew <= '0;
      r_W_src  <= '0;
    end else begin
      if (stall) begin
        r_E_a3   <= '0;
        r_E_rs   <= '0;
        r_E_rt   <= '0;
        r_E_tnew <= '0;
        r_E_src  <= '0;
      end else begin
        r_E_a3   <= D_A3;
        r_E_rs   <= D_rs;
        r_E_rt   <= D_rt;
        r_E_tnew <= D_tnew;
        r_E_src  <= D_src;
      end
      r_M_a3   <= r_E_a3;
      r_M_rt   <= r_E_rt;
      r_M_tnew <= dec_tnew(r_E_tnew);
      r_M_src  <= r_E_src;
      r_W_a3   <= r_M_a3;
      r_W_tnew <= dec_tnew(r_M_tnew);
      r_W_src  <= r_M_src;
    end
  end

  // Stall and forwarding decisions, purely from the records and current D/MDU inputs.
  always_comb begin
    w_hz_rs = hazard(D_rs, D_tuse_rs, r_E_a3, r_E_tnew, r_M_a3, r_M_tnew);
    w_hz_rt = hazard(D_rt, D_tuse_rt, r_E_a3, r_E_tnew, r_M_a3, r_M_tnew);
    w_hz_md = D_is_md & E_md_busy;
    stall   = w_hz_rs | w_hz_rt | w_hz_md;
    F_en    = ~stall;
    D_en    = ~stall;
    E_clr   = stall;

    E_fwd_src_sel = src_sel(r_E_a3, r_E_tnew, r_E_src);
    M_fwd_src_sel = src_sel(r_M_a3, r_M_tnew, r_M_src);
    W_fwd_src_sel = src_sel(r_W_a3, r_W_tnew, r_W_src);

    D_rs_fwd = d_sel(D_rs, r_E_a3, r_E_tnew, r_M_a3, r_M_tnew, r_W_a3, r_W_tnew);
    D_rt_fwd = d_sel(D_rt, r_E_a3, r_E_tnew, r_M_a3, r_M_tnew, r_W_a3, r_W_tnew);
    E_rs_fwd = e_sel(r_E_rs, r_M_a3, r_M_tnew, r_W_a3, r_W_tnew);
    E_rt_fwd = e_sel(r_E_rt, r_M_a3, r_M_tnew, r_W_a3, r_W_tnew);
    M_rt_fwd = ((r_M_rt != 5'd0) && (r_W_a3 == r_M_rt) && (r_W_tnew == 2'd0)) ? 2'd3 : 2'd0;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed pipeline scenarios with literal expectations,
// followed by random traffic. Every cycle is compared against an in-flight
// instruction list model.
module tb_hazard_ctrl;

  localparam logic [2:0] CAL = 3'd1;
  localparam logic [2:0] DMR = 3'd2;
  localparam logic [2:0] PC8 = 3'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic [2:0] D_src;
  logic       D_is_md, E_md_busy;
  logic       stall, F_en, D_en, E_clr;
  logic [2:0] E_fwd_src_sel, M_fwd_src_sel, W_fwd_src_sel;
  logic [1:0] D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_A3(D_A3), .D_tnew(D_tnew), .D_src(D_src),
    .D_is_md(D_is_md), .E_md_busy(E_md_busy),
    .stall(stall), .F_en(F_en), .D_en(D_en), .E_clr(E_clr),
    .E_fwd_src_sel(E_fwd_src_sel), .M_fwd_src_sel(M_fwd_src_sel),
    .W_fwd_src_sel(W_fwd_src_sel),
    .D_rs_fwd(D_rs_fwd), .D_rt_fwd(D_rt_fwd),
    .E_rs_fwd(E_rs_fwd), .E_rt_fwd(E_rt_fwd), .M_rt_fwd(M_rt_fwd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: list of in-flight instructions, index = pipeline distance past D
  // (0 = E, 1 = M, 2 = W). Each keeps its Tnew as of entering E; the remaining
  // Tnew is that value minus the distance, floored at zero.
  typedef struct {
    int a3;
    int tn;
    int src;
    int rs;
    int rt;
  } ins_t;

  ins_t fl[3];
  bit   mvalid = 1'b0;

  function automatic int rem(input ins_t e, input int k);
    return (e.tn > k) ? e.tn - k : 0;
  endfunction

  function automatic bit waits(input int r, input int tuse);
    bit h = 1'b0;
    if (r != 0 && tuse < 3)
      for (int k = 0; k < 2; k++)
        if (fl[k].a3 == r && tuse < rem(fl[k], k)) h = 1'b1;
    return h;
  endfunction

  // Searches stages first..2 for the nearest producer of r; codes are stage+1.
  function automatic int nearest(input int r, input int first);
    int s = 0;
    bit found = 1'b0;
    if (r != 0)
      for (int k = first; k < 3; k++)
        if (!found && fl[k].a3 == r) begin
          found = 1'b1;
          s = (rem(fl[k], k) == 0) ? k + 1 : 0;
        end
    return s;
  endfunction

  // Per-cycle comparison against the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int  est;
        ins_t nx;
        est = (waits(D_rs, D_tuse_rs) || waits(D_rt, D_tuse_rt) ||
               (D_is_md && E_md_busy)) ? 1 : 0;
        if (mvalid) begin
          chk("m_stall", stall, est);
          chk("m_F_en", F_en, 1 - est);
          chk("m_D_en", D_en, 1 - est);
          chk("m_E_clr", E_clr, est);
          chk("m_E_src", E_fwd_src_sel,
              (fl[0].a3 != 0 && rem(fl[0], 0) == 0) ? fl[0].src : 0);
          chk("m_M_src", M_fwd_src_sel,
              (fl[1].a3 != 0 && rem(fl[1], 1) == 0) ? fl[1].src : 0);
          chk("m_W_src", W_fwd_src_sel,
              (fl[2].a3 != 0 && rem(fl[2], 2) == 0) ? fl[2].src : 0);
          chk("m_D_rs_fwd", D_rs_fwd, nearest(D_rs, 0));
          chk("m_D_rt_fwd", D_rt_fwd, nearest(D_rt, 0));
          chk("m_E_rs_fwd", E_rs_fwd, nearest(fl[0].rs, 1));
          chk("m_E_rt_fwd", E_rt_fwd, nearest(fl[0].rt, 1));
          chk("m_M_rt_fwd", M_rt_fwd,
              (fl[1].rt != 0 && fl[2].a3 == fl[1].rt && rem(fl[2], 2) == 0) ? 3 : 0);
        end
        if (reset) begin
          for (int k = 0; k < 3; k++) fl[k] = '{0, 0, 0, 0, 0};
          mvalid = 1'b1;
        end else begin
          nx = (est != 0) ? '{0, 0, 0, 0, 0}
                          : '{int'(D_A3), int'(D_tnew), int'(D_src), int'(D_rs), int'(D_rt)};
          fl[2] = fl[1];
          fl[1] = fl[0];
          fl[0] = nx;
        end
      end
    end
  end

  // Presents one D-stage instruction for one cycle, settling before the negedge.
  task automatic cyc(input int rs, input int trs, input int rt, input int trt,
                     input int a3, input int tn, input int src,
                     input bit md, input bit busy);
    @(posedge clk);
    #1;
    D_rs = 5'(rs); D_tuse_rs = 2'(trs);
    D_rt = 5'(rt); D_tuse_rt = 2'(trt);
    D_A3 = 5'(a3); D_tnew = 2'(tn); D_src = 3'(src);
    D_is_md = md; E_md_busy = busy;
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(0, 3, 0, 3, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    D_rs = '0; D_rt = '0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
    D_A3 = '0; D_tnew = '0; D_src = '0; D_is_md = 1'b0; E_md_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_E_src", E_fwd_src_sel, 0);
    chk("rst_M_src", M_fwd_src_sel, 0);
    chk("rst_W_src", W_fwd_src_sel, 0);
    chk("rst_E_rs_fwd", E_rs_fwd, 0);
    chk("rst_M_rt_fwd", M_rt_fwd, 0);

    // lw $3 (tnew 2) then addu $4,$3,$2
    cyc(1, 1, 3, 3, 3, 2, DMR, 1'b0, 1'b0);
    chk("lw_nostall", stall, 0);
    cyc(3, 1, 2, 1, 4, 1, CAL, 1'b0, 1'b0);
    chk("lw_use_stall", stall, 1);
    chk("lw_use_E_clr", E_clr, 1);
    chk("lw_use_F_en", F_en, 0);
    cyc(3, 1, 2, 1, 4, 1, CAL, 1'b0, 1'b0);
    chk("lw_use_release", stall, 0);
    chk("lw_M_src_notready", M_fwd_src_sel, 0);
    chk("lw_D_rs_fwd", D_rs_fwd, 0);
    nops(1);
    chk("lw_W_src", W_fwd_src_sel, DMR);
    chk("addu_E_rs_fwd", E_rs_fwd, 3);
    chk("addu_E_rt_fwd", E_rt_fwd, 0);
    chk("addu_E_src", E_fwd_src_sel, 0);
    nops(3);

    // addu $5 then beq $5
    cyc(0, 3, 0, 3, 5, 1, CAL, 1'b0, 1'b0);
    cyc(5, 0, 0, 3, 0, 0, 0, 1'b0, 1'b0);
    chk("beq_stall", stall, 1);
    cyc(5, 0, 0, 3, 0, 0, 0, 1'b0, 1'b0);
    chk("beq_release", stall, 0);
    chk("beq_D_rs_fwd", D_rs_fwd, 2);
    chk("beq_M_src", M_fwd_src_sel, CAL);
    nops(3);

    // jal then jr $31
    cyc(0, 3, 0, 3, 31, 0, PC8, 1'b0, 1'b0);
    cyc(31, 0, 0, 3, 0, 0, 0, 1'b0, 1'b0);
    chk("jr_stall", stall, 0);
    chk("jr_D_rs_fwd", D_rs_fwd, 1);
    chk("jal_E_src", E_fwd_src_sel, PC8);
    nops(3);

    // writer to $0 then reader of $0
    cyc(0, 3, 0, 3, 0, 1, CAL, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("r0_stall", stall, 0);
    chk("r0_D_rs_fwd", D_rs_fwd, 0);
    chk("r0_D_rt_fwd", D_rt_fwd, 0);
    chk("r0_E_src", E_fwd_src_sel, 0);
    nops(3);

    // $7 ready in M but E holds a newer unready $7: E wins, tuse 1 == tnew 1
    cyc(0, 3, 0, 3, 7, 0, CAL, 1'b0, 1'b0);
    cyc(0, 3, 0, 3, 7, 1, CAL, 1'b0, 1'b0);
    cyc(7, 1, 0, 3, 0, 0, 0, 1'b0, 1'b0);
    chk("prio_stall", stall, 0);
    chk("prio_D_rs_fwd", D_rs_fwd, 0);
    chk("prio_M_src", M_fwd_src_sel, CAL);
    nops(3);

    // mult busy for 5 cycles with mflo waiting in D
    cyc(8, 1, 9, 1, 0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 3, 0, 3, 10, 1, CAL, 1'b1, 1'b1);
      chk("md_stall", stall, 1);
      chk("md_F_en", F_en, 0);
      chk("md_D_en", D_en, 0);
    end
    cyc(0, 3, 0, 3, 10, 1, CAL, 1'b1, 1'b0);
    chk("md_release", stall, 0);
    nops(3);

    // reset arriving while a two-cycle load-use stall is in progress
    cyc(1, 1, 0, 3, 3, 3, DMR, 1'b0, 1'b0);
    cyc(3, 1, 0, 3, 4, 1, CAL, 1'b0, 1'b0);
    chk("rst_mid_stall1", stall, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall2", stall, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_cleared", stall, 0);
    chk("rst_mid_M_src", M_fwd_src_sel, 0);
    nops(2);

    // random traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom_range(0, 59) == 0);
      D_rs      = 5'($urandom_range(0, 3));
      D_rt      = 5'($urandom_range(0, 3));
      D_tuse_rs = 2'($urandom_range(0, 3));
      D_tuse_rt = 2'($urandom_range(0, 3));
      D_A3      = 5'($urandom_range(0, 3));
      D_tnew    = 2'($urandom_range(0, 3));
      D_src     = 3'($urandom_range(0, 3));
      D_is_md   = ($urandom_range(0, 3) == 0);
      E_md_busy = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
